// File: rtl/load_align_unit.sv
// load_align_unit: load-data alignment between memory stage and write-back (byte/half/word/dword, sign/zero extend).
// Optional macro UNALIGNED_SPLIT_EN services misaligned loads, using a second word read when the access spans two words.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = OFF_W + 3;
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} stateT;
  stateT state, nextState;
  logic [OFF_W-1:0] offQ;
  logic [1:0] sizeQ;
  logic unsQ, rdEnQ, rspErrQ, reqErr, split, accept, signBit;
  logic [DATA_W-1:0] lowQ, rspDataQ, field, mask, ext;
  logic [ADDR_W-1:0] rdAddrQ;
  logic [2*DATA_W-1:0] combined;
  logic [IDX_W-1:0] signIdx;
  assign accept = state == IDLE && req_valid;
`ifdef UNALIGNED_SPLIT_EN
  assign reqErr = DATA_W == 32 && req_size == 2'b11;
  assign split = (int'(offQ) + (1 << sizeQ)) > BYTES;
`else
  logic misaligned;
  assign misaligned = (req_addr[OFF_W-1:0] & OFF_W'((1 << req_size) - 1)) != '0;
  assign reqErr = (DATA_W == 32 && req_size == 2'b11) || misaligned;
  assign split = 1'b0;
`endif
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = !req_valid ? IDLE : reqErr ? RESP : RD0;
      RD0:     nextState = !mem_rd_valid ? RD0 : split ? RD1 : RESP;
      RD1:     nextState = mem_rd_valid ? RESP : RD1;
      RESP:    nextState = rsp_ready ? IDLE : RESP;
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    mem_rd_en = rdEnQ;
    mem_rd_addr = rdAddrQ;
    rsp_data = rspDataQ;
    rsp_err = rspErrQ;
  end
  // The high half of the combined window is only meaningful on the second read of a split access.
  always_comb begin
    combined = state == RD1 ? {mem_rd_data, lowQ} : {{DATA_W{1'b0}}, mem_rd_data};
    field = DATA_W'(combined >> {offQ, 3'b000});
    mask = sizeQ == 2'(OFF_W) ? '1 : ~({DATA_W{1'b1}} << (8 << sizeQ));
    signIdx = IDX_W'((8 << sizeQ) - 1);
    signBit = !unsQ && field[signIdx];
    ext = (field & mask) | ({DATA_W{signBit}} & ~mask);
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      offQ <= '0;
      sizeQ <= '0;
      unsQ <= 1'b0;
      rdEnQ <= 1'b0;
      rdAddrQ <= '0;
      lowQ <= '0;
      rspDataQ <= '0;
      rspErrQ <= 1'b0;
    end else begin
      rdEnQ <= 1'b0;
      if (accept) begin
        offQ <= req_addr[OFF_W-1:0];
        sizeQ <= req_size;
        unsQ <= req_unsigned;
        rdEnQ <= !reqErr;
        rdAddrQ <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        rspDataQ <= '0;
        rspErrQ <= reqErr;
      end else if (state == RD0 && mem_rd_valid) begin
        lowQ <= mem_rd_data;
        rdEnQ <= split;
        if (split) rdAddrQ <= rdAddrQ + ADDR_W'(BYTES);
        else rspDataQ <= ext;
      end else if (state == RD1 && mem_rd_valid) begin
        rspDataQ <= ext;
      end
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed bench for load_align_unit (32-bit instance plus a 64-bit instance for dword loads).
module tb_load_align_unit;
  logic Clk = 0, Rst_n = 0;
  always #5 Clk = ~Clk;
  logic req_valid = 0, req_ready, req_unsigned = 0, mem_rd_en, mem_rd_valid = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] req_addr = 0, mem_rd_addr, mem_rd_data = 0, rsp_data;
  logic [1:0] req_size = 0;
  logic reqValid64 = 0, reqReady64, reqUns64 = 0, memRdEn64, memRdValid64 = 0;
  logic rspValid64, rspReady64 = 0, rspErr64;
  logic [31:0] reqAddr64 = 0, memRdAddr64;
  logic [63:0] memRdData64 = 0, rspData64;
  logic [1:0] reqSize64 = 0;
  int compared = 0, mismatched = 0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err));

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(reqValid64), .req_ready(reqReady64), .req_addr(reqAddr64),
    .req_size(reqSize64), .req_unsigned(reqUns64), .mem_rd_en(memRdEn64), .mem_rd_addr(memRdAddr64),
    .mem_rd_data(memRdData64), .mem_rd_valid(memRdValid64), .rsp_valid(rspValid64), .rsp_ready(rspReady64),
    .rsp_data(rspData64), .rsp_err(rspErr64));

  typedef struct {
    string name;
    logic [31:0] addr;
    logic [1:0] size;
    logic uns;
    logic [31:0] w0, w1, expData;
    logic expErr;
    int expReads, expLat;
    logic [31:0] expA0, expA1;
  } vecT;

  // Acts as a latency-1 memory: each read strobe is answered on the following cycle (w0 first, then w1).
  task automatic run_load(input vecT v, input bit ack, output logic [31:0] data, output logic err,
                          output int nRd, output logic [31:0] a0, output logic [31:0] a1, output int lat);
    bit pend = 0;
    nRd = 0; a0 = 0; a1 = 0;
    @(negedge Clk);
    req_addr = v.addr; req_size = v.size; req_unsigned = v.uns; req_valid = 1;
    @(negedge Clk);
    req_valid = 0;
    lat = 1;
    while (lat < 20) begin
      mem_rd_valid = pend;
      mem_rd_data = nRd == 1 ? v.w0 : v.w1;
      pend = 0;
      if (mem_rd_en) begin
        if (nRd == 0) a0 = mem_rd_addr; else a1 = mem_rd_addr;
        nRd++;
        pend = 1;
      end
      if (rsp_valid) break;
      @(negedge Clk);
      lat++;
    end
    mem_rd_valid = 0;
    data = rsp_data;
    err = rsp_err;
    if (ack) begin
      rsp_ready = 1;
      @(negedge Clk);
      rsp_ready = 0;
    end
  endtask

  task automatic check_vec(input vecT v);
    logic [31:0] d, a0, a1;
    logic e;
    int n, lat;
    run_load(v, 1, d, e, n, a0, a1, lat);
    compared++;
    if ({e, d} !== {v.expErr, v.expData}) begin
      mismatched++;
      $display("FAIL %s result: got err=%0b data=%h, want err=%0b data=%h", v.name, e, d, v.expErr, v.expData);
    end
    compared++;
    if (n !== v.expReads || lat !== v.expLat) begin
      mismatched++;
      $display("FAIL %s timing: got reads=%0d lat=%0d, want reads=%0d lat=%0d", v.name, n, lat, v.expReads, v.expLat);
    end
    if (v.expReads > 0) begin
      compared++;
      if (a0 !== v.expA0 || (v.expReads > 1 && a1 !== v.expA1)) begin
        mismatched++;
        $display("FAIL %s addr: got %h/%h, want %h/%h", v.name, a0, a1, v.expA0, v.expA1);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if ({req_ready, mem_rd_en, rsp_valid, rsp_err} !== 4'b1000 || rsp_data !== 0 || mem_rd_addr !== 0) begin
      mismatched++;
      $display("FAIL reset32: got rdy/en/vld/err=%b%b%b%b data=%h addr=%h, want 1000 0 0",
               req_ready, mem_rd_en, rsp_valid, rsp_err, rsp_data, mem_rd_addr);
    end
    compared++;
    if ({reqReady64, memRdEn64, rspValid64, rspErr64} !== 4'b1000 || rspData64 !== 0) begin
      mismatched++;
      $display("FAIL reset64: got rdy/en/vld/err=%b%b%b%b data=%h, want 1000 0",
               reqReady64, memRdEn64, rspValid64, rspErr64, rspData64);
    end
    @(negedge Clk);
    Rst_n = 1;
    @(negedge Clk);
    compared++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset: got req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_aligned();
    vecT t[7];
    t[0] = '{"half_signed",  32'h102, 2'd1, 1'b0, 32'h8001_1234, 0, 32'hFFFF_8001, 0, 1, 3, 32'h100, 0};
    t[1] = '{"half_unsigned",32'h102, 2'd1, 1'b1, 32'h8001_1234, 0, 32'h0000_8001, 0, 1, 3, 32'h100, 0};
    t[2] = '{"half_low",     32'h100, 2'd1, 1'b0, 32'h8001_1234, 0, 32'h0000_1234, 0, 1, 3, 32'h100, 0};
    t[3] = '{"byte_pos",     32'h203, 2'd0, 1'b0, 32'h7F00_0000, 0, 32'h0000_007F, 0, 1, 3, 32'h200, 0};
    t[4] = '{"byte_neg",     32'h203, 2'd0, 1'b0, 32'h8000_0000, 0, 32'hFFFF_FF80, 0, 1, 3, 32'h200, 0};
    t[5] = '{"byte_uns",     32'h201, 2'd0, 1'b1, 32'h0000_F500, 0, 32'h0000_00F5, 0, 1, 3, 32'h200, 0};
    t[6] = '{"word",         32'h104, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 1, 3, 32'h104, 0};
    foreach (t[i]) check_vec(t[i]);
  endtask

  task automatic test_errors();
    vecT t[3];
    t[0] = '{"dword_on_32", 32'h100, 2'd3, 1'b0, 32'h1111_1111, 0, 32'h0, 1, 0, 1, 0, 0};
`ifdef UNALIGNED_SPLIT_EN
    t[1] = '{"half_split",  32'h103, 2'd1, 1'b1, 32'hAB00_0000, 32'h0000_00CD, 32'h0000_CDAB, 0, 2, 5, 32'h100, 32'h104};
    t[2] = '{"half_inword", 32'h101, 2'd1, 1'b0, 32'h00AB_CD00, 0, 32'hFFFF_ABCD, 0, 1, 3, 32'h100, 0};
`else
    t[1] = '{"half_split",  32'h103, 2'd1, 1'b1, 32'hAB00_0000, 32'h0000_00CD, 32'h0, 1, 0, 1, 0, 0};
    t[2] = '{"half_inword", 32'h101, 2'd1, 1'b0, 32'h00AB_CD00, 0, 32'h0, 1, 0, 1, 0, 0};
`endif
    foreach (t[i]) check_vec(t[i]);
  endtask

  task automatic test_backpressure();
    vecT v = '{"bp", 32'h100, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] d, a0, a1;
    logic e;
    int n, lat;
    run_load(v, 0, d, e, n, a0, a1, lat);
    req_valid = 1; req_addr = 32'h204; req_size = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      compared++;
      if ({rsp_valid, req_ready, mem_rd_en, rsp_err} !== 4'b1000 || rsp_data !== 32'hCAFE_F00D) begin
        mismatched++;
        $display("FAIL backpressure[%0d]: got vld/rdy/en/err=%b%b%b%b data=%h, want 1000 cafef00d",
                 i, rsp_valid, req_ready, mem_rd_en, rsp_err, rsp_data);
      end
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge Clk);
    rsp_ready = 0;
    compared++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: got req_ready=%b rsp_valid=%b mem_rd_en=%b, want 1 0 0", req_ready, rsp_valid, mem_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(negedge Clk);
    req_addr = 32'h100; req_size = 2'd2; req_unsigned = 0; req_valid = 1;
    @(negedge Clk);
    req_valid = 0;
    compared++;
    if (mem_rd_en !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_rd0: got mem_rd_en=%b, want 1", mem_rd_en);
    end
    #1 Rst_n = 0;
    #1;
    compared++;
    if ({req_ready, mem_rd_en, rsp_valid, rsp_err} !== 4'b1000 || mem_rd_addr !== 0) begin
      mismatched++;
      $display("FAIL mid_reset: got rdy/en/vld/err=%b%b%b%b addr=%h, want 1000 0",
               req_ready, mem_rd_en, rsp_valid, rsp_err, mem_rd_addr);
    end
    @(negedge Clk);
    Rst_n = 1;
    mem_rd_valid = 1; mem_rd_data = 32'h1234_5678;
    @(negedge Clk);
    mem_rd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || mem_rd_en) seen = 1;
      @(negedge Clk);
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL late_valid: got spurious response/read=1, want 0");
    end
  endtask

  task automatic run64(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] w,
                       input logic [63:0] expData, input logic [31:0] expAddr, input string name);
    @(negedge Clk);
    reqAddr64 = addr; reqSize64 = size; reqUns64 = 0; reqValid64 = 1;
    @(negedge Clk);
    reqValid64 = 0;
    compared++;
    if (memRdEn64 !== 1'b1 || memRdAddr64 !== expAddr) begin
      mismatched++;
      $display("FAIL %s read: got en=%b addr=%h, want 1 %h", name, memRdEn64, memRdAddr64, expAddr);
    end
    @(negedge Clk);
    memRdValid64 = 1; memRdData64 = w;
    @(negedge Clk);
    memRdValid64 = 0;
    compared++;
    if ({rspValid64, rspErr64} !== 2'b10 || rspData64 !== expData) begin
      mismatched++;
      $display("FAIL %s result: got vld/err=%b%b data=%h, want 10 %h", name, rspValid64, rspErr64, rspData64, expData);
    end
    rspReady64 = 1;
    @(negedge Clk);
    rspReady64 = 0;
  endtask

  task automatic test_dword64();
    run64(32'h8, 2'd3, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 32'h8, "dword64");
    run64(32'hC, 2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 32'h8, "word64_hi");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_dword64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog");
  end
endmodule
